// File: rtl/dense_act_if.sv
// Handshake and operand bus for dense_act_engine: the requester drives operands
// and start, and the engine returns status and the per-neuron results.
interface dense_act_if #(
  parameter int IN_SIZE    = 16,
  parameter int OUT_SIZE   = 4,
  parameter int DATA_WIDTH = 8
);
  logic                                   start;
  logic [DATA_WIDTH*IN_SIZE-1:0]          input_data;
  logic [DATA_WIDTH*IN_SIZE*OUT_SIZE-1:0] weights;
  logic [DATA_WIDTH*OUT_SIZE-1:0]         biases;
  logic                                   busy;
  logic                                   done;
  logic [DATA_WIDTH*OUT_SIZE-1:0]         output_data;
  logic [OUT_SIZE-1:0]                    binary_output;

  modport master (
    output start, input_data, weights, biases,
    input  busy, done, output_data, binary_output
  );

  modport slave (
    input  start, input_data, weights, biases,
    output busy, done, output_data, binary_output
  );
endinterface

// File: rtl/dense_act_engine.sv
// Sequential fully-connected layer, one MAC per clock, with ReLU+shift and sigmoid-threshold outputs.
// Define DENSE_SATURATE_EN to clamp positive results to the max signed value instead of wrapping.
module dense_act_engine #(
  parameter int IN_SIZE    = 16,
  parameter int OUT_SIZE   = 4,
  parameter int DATA_WIDTH = 8,
  parameter int SHIFT      = 4
) (
  input  logic         clk,
  input  logic         rst,
  dense_act_if.slave   bus
);
  localparam int ACC_W = 2*DATA_WIDTH + $clog2(IN_SIZE) + 1;
  localparam int IW    = (IN_SIZE  > 1) ? $clog2(IN_SIZE)  : 1;
  localparam int OW    = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
  localparam logic [IW-1:0] I_LAST = IW'(IN_SIZE - 1);
  localparam logic [OW-1:0] J_LAST = OW'(OUT_SIZE - 1);
`ifdef DENSE_SATURATE_EN
  localparam logic signed [ACC_W-1:0] POS_MAX = ACC_W'((1 << (DATA_WIDTH-1)) - 1);
`endif

  typedef enum logic [1:0] {IDLE, ACCUM, WRITE, FIN} state_t;
  state_t state, state_nxt;

  logic signed [DATA_WIDTH-1:0]   x_q [IN_SIZE];
  logic signed [DATA_WIDTH-1:0]   w_q [OUT_SIZE][IN_SIZE];
  logic signed [DATA_WIDTH-1:0]   b_q [OUT_SIZE];
  logic [IW-1:0]                  i_cnt;
  logic [OW-1:0]                  j_cnt;
  logic signed [ACC_W-1:0]        acc;
  logic signed [ACC_W-1:0]        r;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic [DATA_WIDTH-1:0]          act;
  logic [DATA_WIDTH*OUT_SIZE-1:0] out_q;
  logic [OUT_SIZE-1:0]            bin_q;
  logic                           capture;

  assign capture           = (state == IDLE) && bus.start;
  assign bus.output_data   = out_q;
  assign bus.binary_output = bin_q;

  // Operands are snapshotted so the requester may change them once the run starts.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int i = 0; i < IN_SIZE; i++)
        x_q[i] <= bus.input_data[i*DATA_WIDTH +: DATA_WIDTH];
      for (int j = 0; j < OUT_SIZE; j++) begin
        b_q[j] <= bus.biases[j*DATA_WIDTH +: DATA_WIDTH];
        for (int i = 0; i < IN_SIZE; i++)
          w_q[j][i] <= bus.weights[(j*IN_SIZE+i)*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    bus.busy  = (state != IDLE);
    bus.done  = (state == FIN);
    case (state)
      IDLE:    if (bus.start) state_nxt = ACCUM;
      ACCUM:   if (i_cnt == I_LAST) state_nxt = WRITE;
      WRITE:   state_nxt = (j_cnt == J_LAST) ? FIN : ACCUM;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    prod = x_q[i_cnt] * w_q[j_cnt][i_cnt];
    r    = acc >>> SHIFT;
    act  = '0;
    if (r >= 0) begin
`ifdef DENSE_SATURATE_EN
      act = (r > POS_MAX) ? POS_MAX[DATA_WIDTH-1:0] : r[DATA_WIDTH-1:0];
`else
      act = r[DATA_WIDTH-1:0];
`endif
    end
  end

  // acc >= 0 is exactly sigmoid(acc) >= 0.5, so the decision is the inverted sign bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      i_cnt <= '0;
      j_cnt <= '0;
      out_q <= '0;
      bin_q <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          i_cnt <= '0;
          j_cnt <= '0;
        end
        ACCUM: begin
          acc   <= ((i_cnt == '0) ? ACC_W'(b_q[j_cnt]) : acc) + ACC_W'(prod);
          i_cnt <= (i_cnt == I_LAST) ? '0 : i_cnt + 1'b1;
        end
        WRITE: begin
          out_q[j_cnt*DATA_WIDTH +: DATA_WIDTH] <= act;
          bin_q[j_cnt] <= ~acc[ACC_W-1];
          j_cnt        <= (j_cnt == J_LAST) ? '0 : j_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_dense_act_engine.sv
// Self-checking bench for dense_act_engine: directed plan cases plus random operands
// checked against an integer-arithmetic reference of the layer.
module tb_dense_act_engine;
  localparam int IN  = 16;
  localparam int OUT = 4;
  localparam int DW  = 8;
  localparam int SH  = 4;
  localparam int LAT = OUT*(IN+1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dense_act_if #(.IN_SIZE(IN), .OUT_SIZE(OUT), .DATA_WIDTH(DW)) bus();

  dense_act_engine #(.IN_SIZE(IN), .OUT_SIZE(OUT), .DATA_WIDTH(DW), .SHIFT(SH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;
  int xs [IN];
  int ws [OUT][IN];
  int bs [OUT];
  logic [DW*OUT-1:0] exp_out;
  logic [OUT-1:0]    exp_bin;

  task automatic apply_ops();
    for (int i = 0; i < IN; i++) bus.input_data[i*DW +: DW] = DW'(xs[i]);
    for (int j = 0; j < OUT; j++) begin
      bus.biases[j*DW +: DW] = DW'(bs[j]);
      for (int i = 0; i < IN; i++) bus.weights[(j*IN+i)*DW +: DW] = DW'(ws[j][i]);
    end
  endtask

  task automatic fill_ops(input int xv, input int wv, input int bv);
    for (int i = 0; i < IN; i++) xs[i] = xv;
    for (int j = 0; j < OUT; j++) begin
      bs[j] = bv;
      for (int i = 0; i < IN; i++) ws[j][i] = wv;
    end
  endtask

  task automatic rand_ops();
    for (int i = 0; i < IN; i++) xs[i] = int'($urandom_range(255)) - 128;
    for (int j = 0; j < OUT; j++) begin
      bs[j] = int'($urandom_range(255)) - 128;
      for (int i = 0; i < IN; i++) ws[j][i] = int'($urandom_range(255)) - 128;
    end
  endtask

  // Reference: neuron = bias + dot product, then shift/ReLU and the sign decision.
  task automatic model();
    int acc, r, v;
    for (int j = 0; j < OUT; j++) begin
      acc = bs[j];
      for (int i = 0; i < IN; i++) acc += xs[i] * ws[j][i];
      r = acc >>> SH;
      if (r < 0) v = 0;
      else begin
`ifdef DENSE_SATURATE_EN
        v = (r > 2**(DW-1)-1) ? 2**(DW-1)-1 : r;
`else
        v = r % (2**DW);
`endif
      end
      exp_out[j*DW +: DW] = DW'(v);
      exp_bin[j]          = (acc >= 0);
    end
  endtask

  // Starts a run; optionally pulses start with fresh operands at cycle poke_at.
  task automatic run_layer(input int poke_at, output int lat, output int busy_hi, output int done_cnt);
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    lat = -1; busy_hi = 0; done_cnt = 0;
    for (int c = 1; c <= LAT + 20; c++) begin
      if (c == poke_at) begin
        rand_ops();
        apply_ops();
        bus.start = 1'b1;
      end
      @(posedge clk); #1 bus.start = 1'b0;
      if (bus.busy === 1'b1 && c <= LAT) busy_hi++;
      if (bus.done === 1'b1) begin
        done_cnt++;
        if (lat < 0) lat = c;
      end
    end
  endtask

  task automatic check_run(input string name, input int lat, input int done_cnt);
    total_cnt++;
    if (lat !== LAT) $display("FAIL %s latency got %0d want %0d", name, lat, LAT);
    else pass_cnt++;
    total_cnt++;
    if (done_cnt !== 1) $display("FAIL %s done_pulses got %0d want 1", name, done_cnt);
    else pass_cnt++;
    total_cnt++;
    if (bus.output_data !== exp_out) $display("FAIL %s output_data got %h want %h", name, bus.output_data, exp_out);
    else pass_cnt++;
    total_cnt++;
    if (bus.binary_output !== exp_bin) $display("FAIL %s binary_output got %b want %b", name, bus.binary_output, exp_bin);
    else pass_cnt++;
    total_cnt++;
    if (bus.busy !== 1'b0) $display("FAIL %s busy_after got %b want 0", name, bus.busy);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    fill_ops(0, 0, 0);
    apply_ops();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    total_cnt++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) $display("FAIL reset_status got busy=%b done=%b want 0/0", bus.busy, bus.done);
    else pass_cnt++;
    total_cnt++;
    if (bus.output_data !== '0 || bus.binary_output !== '0)
      $display("FAIL reset_outputs got %h/%b want 0/0", bus.output_data, bus.binary_output);
    else pass_cnt++;
  endtask

  task automatic test_ones();
    int lat, bh, dc;
    fill_ops(1, 1, 0); apply_ops(); model();
    run_layer(-1, lat, bh, dc);
    total_cnt++;
    if (bh !== LAT) $display("FAIL ones busy_cycles got %0d want %0d", bh, LAT);
    else pass_cnt++;
    check_run("ones", lat, dc);
  endtask

  task automatic test_negative();
    int lat, bh, dc;
    fill_ops(1, -1, 0); apply_ops(); model();
    run_layer(-1, lat, bh, dc);
    check_run("negative", lat, dc);
  endtask

  task automatic test_threshold();
    int lat, bh, dc;
    fill_ops(5, 0, 0); bs[2] = -1; apply_ops(); model();
    run_layer(-1, lat, bh, dc);
    check_run("threshold", lat, dc);
  endtask

  task automatic test_saturate();
    int lat, bh, dc;
    fill_ops(127, 127, 0); apply_ops(); model();
    run_layer(-1, lat, bh, dc);
    check_run("big_product", lat, dc);
  endtask

  task automatic test_abort();
    int lat, bh, dc, late_done;
    rand_ops(); apply_ops();
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    total_cnt++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) $display("FAIL abort_status got busy=%b done=%b want 0/0", bus.busy, bus.done);
    else pass_cnt++;
    total_cnt++;
    if (bus.output_data !== '0 || bus.binary_output !== '0)
      $display("FAIL abort_outputs got %h/%b want 0/0", bus.output_data, bus.binary_output);
    else pass_cnt++;
    @(posedge clk); #1 rst = 1'b0;
    late_done = 0;
    for (int c = 0; c < LAT; c++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) late_done++;
    end
    total_cnt++;
    if (late_done !== 0) $display("FAIL abort_no_done got %0d active cycles want 0", late_done);
    else pass_cnt++;
    fill_ops(2, 3, 7); apply_ops(); model();
    run_layer(-1, lat, bh, dc);
    check_run("after_abort", lat, dc);
  endtask

  task automatic test_restart_ignored();
    int lat, bh, dc;
    rand_ops(); apply_ops(); model();
    run_layer(10, lat, bh, dc);
    check_run("restart_ignored", lat, dc);
  endtask

  task automatic test_start_on_done();
    int lat, bh, dc;
    rand_ops(); apply_ops(); model();
    run_layer(LAT + 1, lat, bh, dc);
    check_run("start_on_done", lat, dc);
  endtask

  task automatic test_random();
    int lat, bh, dc;
    for (int n = 0; n < 6; n++) begin
      rand_ops(); apply_ops(); model();
      run_layer(-1, lat, bh, dc);
      check_run("random", lat, dc);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start      = 1'b0;
    bus.input_data = '0;
    bus.weights    = '0;
    bus.biases     = '0;
    test_reset();
    test_ones();
    test_negative();
    test_threshold();
    test_saturate();
    test_abort();
    test_restart_ignored();
    test_start_on_done();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
